// File: rtl/extremum_finder.sv
// Scans a wrap-capable address window of a 1-cycle-latency RAM and reports the max/min value and its address.
// Optional running sum of scanned words enabled by defining EXTREMUM_SUM_EN.
module extremum_finder #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     mode,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [ADDR_W-1:0]        last_addr,
  output logic                     mem_rd,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_W-1:0]        result,
  output logic [ADDR_W-1:0]        result_addr,
  output logic [DATA_W+ADDR_W-1:0] sum
);

  localparam int SUM_W = DATA_W + ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [ADDR_W-1:0]   mar_r;
  logic [ADDR_W-1:0]   last_r;
  logic [DATA_W-1:0]   mdr_r;
  logic [DATA_W-1:0]   result_r;
  logic [ADDR_W-1:0]   result_addr_r;
  logic                mode_r;
  logic                first_r;
  logic                mem_rd_r;
  logic                busy_r;
  logic                done_r;
  logic                update_s;
  logic                at_last_s;

  // Strict compare keeps the first-encountered address on ties.
  function automatic logic better_f(input logic       find_min,
                                    input logic [DATA_W-1:0] cand,
                                    input logic [DATA_W-1:0] cur);
    if (find_min) begin
      better_f = (cand < cur);
    end else begin
      better_f = (cand > cur);
    end
  endfunction

  // Next-state decode plus update/end-of-window qualifiers.
  always_comb begin
    state_s   = state_r;
    at_last_s = (mar_r == last_r);
    if (first_r) begin
      update_s = 1'b1;
    end else begin
      update_s = better_f(mode_r, mdr_r, result_r);
    end
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_READ;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_READ:  state_s = S_WAIT;
      S_WAIT:  state_s = S_CHECK;
      S_CHECK: begin
        if (at_last_s) begin
          state_s = S_DONE;
        end else begin
          state_s = S_READ;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State register, registered handshake outputs and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= S_IDLE;
      mem_rd_r      <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      mar_r         <= {ADDR_W{1'b0}};
      last_r        <= {ADDR_W{1'b0}};
      mdr_r         <= {DATA_W{1'b0}};
      mode_r        <= 1'b0;
      first_r       <= 1'b0;
      result_r      <= {DATA_W{1'b0}};
      result_addr_r <= {ADDR_W{1'b0}};
    end else begin
      state_r  <= state_s;
      mem_rd_r <= (state_s == S_READ);
      busy_r   <= (state_s != S_IDLE);
      done_r   <= (state_s == S_DONE);
      case (state_r)
        S_IDLE: begin
          if (start) begin
            mode_r  <= mode;
            last_r  <= last_addr;
            mar_r   <= base_addr;
            first_r <= 1'b1;
          end
        end
        S_WAIT: mdr_r <= mem_rdata;
        S_CHECK: begin
          if (update_s) begin
            result_r      <= mdr_r;
            result_addr_r <= mar_r;
            first_r       <= 1'b0;
          end
          if (!at_last_s) begin
            mar_r <= mar_r + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef EXTREMUM_SUM_EN
  logic [SUM_W-1:0] sum_r;

  // Running sum, cleared on an accepted start and accumulated once per element.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_r <= {SUM_W{1'b0}};
    end else if ((state_r == S_IDLE) && start) begin
      sum_r <= {SUM_W{1'b0}};
    end else if (state_r == S_CHECK) begin
      sum_r <= sum_r + SUM_W'(mdr_r);
    end else begin
      sum_r <= sum_r;
    end
  end

  assign sum = sum_r;
`else
  assign sum = {SUM_W{1'b0}};
`endif

  assign mem_rd      = mem_rd_r;
  assign mem_addr    = mar_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign result      = result_r;
  assign result_addr = result_addr_r;

endmodule
